// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multicycle mult/div units: latch operands, pulse start, wait for ready, write back once.
// Latency: start -> LAUNCH (1) -> WAIT (unit latency, at most TIMEOUT cycles) -> DONE writeback (1).
// Backpressure: stall holds F/D/X while busy; `DIV_ZERO_FASTPATH_EN resolves divide-by-zero without starting the divider.
module multdiv_ctrl #(
    parameter int DATA_W       = 32,
    parameter int RD_W         = 5,
    parameter int TIMEOUT      = 48,
    parameter int RSTATUS_REG  = 30,
    parameter int MUL_EXC_CODE = 4,
    parameter int DIV_EXC_CODE = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic              kill,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    input  logic [RD_W-1:0]   rd,
    output logic [DATA_W-1:0] md_operandA,
    output logic [DATA_W-1:0] md_operandB,
    output logic              ctrl_MULT,
    output logic              ctrl_DIV,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_resultRDY,
    output logic              stall,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] opa_q, opb_q, res_q;
    logic [RD_W-1:0]   rd_q;
    logic              mult_q, exc_q, terr_q;
    logic [WD_W-1:0]   wd_q;
    logic              start, fast_zero, wd_hit;

    assign start = start_mult | start_div;

`ifdef DIV_ZERO_FASTPATH_EN
    assign fast_zero = start_div & ~start_mult & (opB == '0);
`else
    assign fast_zero = 1'b0;
`endif

    assign md_operandA = opa_q;
    assign md_operandB = opb_q;
    assign timeout_err = terr_q;

    always_comb begin
        state_d   = state_q;
        wd_hit    = 1'b0;
        stall     = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stall   = 1'b1;
                    state_d = fast_zero ? DONE : LAUNCH;
                end
            end
            LAUNCH: begin
                stall     = 1'b1;
                ctrl_MULT = mult_q;
                ctrl_DIV  = ~mult_q;
                state_d   = kill ? IDLE : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                // kill beats a same-cycle ready; ready beats the watchdog
                if (kill) begin
                    state_d = IDLE;
                end else if (md_resultRDY) begin
                    state_d = DONE;
                end else if (wd_q + WD_W'(1) == WD_W'(TIMEOUT)) begin
                    wd_hit  = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                wb_valid = 1'b1;
                if (exc_q) begin
                    wb_rd   = RD_W'(RSTATUS_REG);
                    wb_data = mult_q ? DATA_W'(MUL_EXC_CODE) : DATA_W'(DIV_EXC_CODE);
                end else begin
                    wb_rd   = rd_q;
                    wb_data = res_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            rd_q    <= '0;
            mult_q  <= 1'b0;
            exc_q   <= 1'b0;
            terr_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opa_q  <= opA;
                        opb_q  <= opB;
                        rd_q   <= rd;
                        mult_q <= start_mult;
                        exc_q  <= fast_zero;
                        res_q  <= '0;
                    end
                end
                LAUNCH: wd_q <= '0;
                WAIT: begin
                    wd_q <= wd_q + WD_W'(1);
                    if (!kill && md_resultRDY) begin
                        res_q <= md_result;
                        exc_q <= md_exception;
                    end
                    if (wd_hit) terr_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: directed scenarios with literal expectations, then random traffic against a transaction-level model.
module tb_multdiv_ctrl;

    localparam int TO = 48;
`ifdef DIV_ZERO_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start_mult, start_div, kill;
    logic [31:0] opA, opB;
    logic [4:0]  rd;
    logic [31:0] md_operandA, md_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception, md_resultRDY;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;

    multdiv_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_mult   (start_mult),
        .start_div    (start_div),
        .kill         (kill),
        .opA          (opA),
        .opB          (opB),
        .rd           (rd),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .timeout_err  (timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Reference model: one operation record, aged in cycles since acceptance
    bit          m_busy, m_done, m_mult, m_exc, m_terr;
    int          m_age;
    logic [31:0] m_a, m_b, m_res;
    logic [4:0]  m_rd;

    always @(negedge clock) begin
        logic        e_stall;
        logic [4:0]  e_wbr;
        logic [31:0] e_wbd;
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_mult = 0; m_exc = 0; m_terr = 0; m_age = 0;
            m_a = 0; m_b = 0; m_res = 0; m_rd = 0;
        end
        e_stall = m_busy || (!m_done && (start_mult || start_div));
        e_wbr   = m_done ? (m_exc ? 5'd30 : m_rd) : 5'd0;
        e_wbd   = m_done ? (m_exc ? (m_mult ? 32'd4 : 32'd5) : m_res) : 32'd0;
        chk("stall", stall, e_stall);
        chk("ctrl_MULT", ctrl_MULT, m_busy && m_age == 1 && m_mult);
        chk("ctrl_DIV", ctrl_DIV, m_busy && m_age == 1 && !m_mult);
        chk("wb_valid", wb_valid, m_done);
        chk("wb_rd", wb_rd, e_wbr);
        chk("wb_data", wb_data, e_wbd);
        chk("md_operandA", md_operandA, m_a);
        chk("md_operandB", md_operandB, m_b);
        chk("timeout_err", timeout_err, m_terr);
        if (reset_n) begin
            if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (kill) m_busy = 0;
                else if (m_age == 1) m_age = 2;
                else if (md_resultRDY) begin
                    m_res = md_result; m_exc = md_exception; m_busy = 0; m_done = 1;
                end else if (m_age - 1 == TO) begin
                    m_terr = 1; m_busy = 0;
                end else m_age++;
            end else if (start_mult || start_div) begin
                m_a = opA; m_b = opB; m_rd = rd; m_mult = start_mult; m_exc = 0; m_res = 0;
                if (FAST && !start_mult && opB == 0) begin
                    m_done = 1; m_exc = 1;
                end else begin
                    m_busy = 1; m_age = 1;
                end
            end
        end
    end

    // Event counters for the directed scenarios
    int mpulse, dpulse, wb_cnt, wb_cyc, stall_cnt, terr_cyc;
    logic [4:0]  last_wbr;
    logic [31:0] last_wbd;
    logic        wb_stall;

    always @(negedge clock) begin
        if (ctrl_MULT) mpulse++;
        if (ctrl_DIV) dpulse++;
        if (stall) stall_cnt++;
        if (timeout_err && terr_cyc < 0) terr_cyc = cyc;
        if (wb_valid) begin
            wb_cnt++; wb_cyc = cyc; last_wbr = wb_rd; last_wbd = wb_data; wb_stall = stall;
        end
    end

    // Unit stub: ready comes stub_cur cycles after the start pulse (0 means never)
    bit          rand_mode = 0;
    bit          stub_armed = 0;
    int          stub_lat = 0, stub_cur = 0, stub_cnt = 0;
    logic [31:0] stub_res = 0;
    bit          stub_exc = 0;

    always @(negedge clock) begin
        if (ctrl_MULT || ctrl_DIV) begin
            stub_armed = 1;
            stub_cnt   = 0;
            if (rand_mode) begin
                stub_cur = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 52));
                stub_res = $urandom;
                stub_exc = ($urandom_range(0, 3) == 0);
            end else begin
                stub_cur = stub_lat;
            end
        end else if (stub_armed) begin
            stub_cnt++;
        end
    end

    always @(posedge clock) begin
        #1;
        if (stub_armed && stub_cur > 0 && stub_cnt + 1 == stub_cur) begin
            md_resultRDY = 1; md_result = stub_res; md_exception = stub_exc;
        end else if (rand_mode && $urandom_range(0, 15) == 0) begin
            md_resultRDY = 1; md_result = $urandom; md_exception = 1'($urandom_range(0, 1));
        end else begin
            md_resultRDY = 0; md_result = $urandom; md_exception = 0;
        end
    end

    int start_cyc;

    task automatic clear_counts();
        mpulse = 0; dpulse = 0; wb_cnt = 0; stall_cnt = 0; terr_cyc = -1; wb_cyc = 0;
    endtask

    task automatic issue(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        @(posedge clock); #1;
        start_mult = sm; start_div = sd; opA = a; opB = b; rd = r; start_cyc = cyc;
        @(posedge clock); #1;
        start_mult = 0; start_div = 0; opA = $urandom; opB = $urandom; rd = 5'($urandom);
    endtask

    task automatic wait_wb(input int budget, input string name);
        int k = 0;
        while (wb_cnt == 0 && k < budget) begin
            @(posedge clock);
            k++;
        end
        if (wb_cnt == 0) chk(name, 0, 1);
    endtask

    initial begin
        reset_n = 0; start_mult = 0; start_div = 0; kill = 0;
        opA = 0; opB = 0; rd = 0; md_resultRDY = 0; md_result = 0; md_exception = 0;
        clear_counts();
        repeat (3) @(negedge clock);
        chk("rst_stall", stall, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_opA", md_operandA, 0);
        chk("rst_timeout_err", timeout_err, 0);
        @(posedge clock); #1 reset_n = 1;

        // Divide 100 / -7 with a 33-cycle unit
        clear_counts();
        stub_lat = 33; stub_res = 32'hFFFFFFF2; stub_exc = 0;
        issue(0, 1, 32'd100, 32'hFFFFFFF9, 5'd9);
        wait_wb(100, "div_wb_missing");
        chk("div_pulses", dpulse, 1);
        chk("div_mult_pulses", mpulse, 0);
        chk("div_wb_rd", last_wbr, 9);
        chk("div_wb_data", last_wbd, 32'hFFFFFFF2);
        chk("div_latency", wb_cyc - start_cyc, 35);
        chk("div_wb_stall", wb_stall, 0);
        chk("div_opB_held", md_operandB, 32'hFFFFFFF9);

        // Multiply overflow
        clear_counts();
        stub_lat = 5; stub_res = 0; stub_exc = 1;
        issue(1, 0, 32'h40000000, 32'd4, 5'd7);
        wait_wb(100, "mulovf_wb_missing");
        repeat (5) @(posedge clock);
        chk("mulovf_wb_rd", last_wbr, 30);
        chk("mulovf_wb_data", last_wbd, 4);
        chk("mulovf_wb_count", wb_cnt, 1);
        chk("mulovf_pulses", mpulse, 1);

        // Divide by zero
        clear_counts();
        stub_lat = 10; stub_res = 0; stub_exc = 1;
        issue(0, 1, 32'd5, 32'd0, 5'd3);
        wait_wb(100, "divzero_wb_missing");
        repeat (3) @(posedge clock);
        chk("divzero_wb_rd", last_wbr, 30);
        chk("divzero_wb_data", last_wbd, 5);
        if (FAST) begin
            chk("divzero_fast_pulses", dpulse, 0);
            chk("divzero_fast_latency", wb_cyc - start_cyc, 1);
            chk("divzero_fast_stalls", stall_cnt, 1);
        end else begin
            chk("divzero_pulses", dpulse, 1);
            chk("divzero_latency", wb_cyc - start_cyc, 12);
        end

        // Kill 10 cycles into WAIT, late ready ignored, then a fresh multiply
        clear_counts();
        stub_lat = 20; stub_res = 32'hAAAA; stub_exc = 0;
        issue(1, 0, 32'd3, 32'd4, 5'd11);
        repeat (11) @(posedge clock);
        #1 kill = 1;
        @(posedge clock); #1 kill = 0;
        repeat (15) @(posedge clock);
        chk("kill_no_wb", wb_cnt, 0);
        stub_lat = 4; stub_res = 32'h1234;
        issue(1, 0, 32'd6, 32'd7, 5'd12);
        wait_wb(100, "kill_second_wb_missing");
        repeat (3) @(posedge clock);
        chk("kill_mult_pulses", mpulse, 2);
        chk("kill_wb_count", wb_cnt, 1);
        chk("kill_wb_rd", last_wbr, 12);
        chk("kill_wb_data", last_wbd, 32'h1234);

        // Unit never answers: watchdog
        clear_counts();
        stub_lat = 0;
        issue(0, 1, 32'd9, 32'd3, 5'd4);
        begin
            int k = 0;
            while (terr_cyc < 0 && k < 100) begin
                @(posedge clock);
                k++;
            end
        end
        @(negedge clock);
        chk("wd_cycle", terr_cyc - start_cyc, 50);
        chk("wd_stall", stall, 0);
        chk("wd_no_wb", wb_cnt, 0);
        repeat (4) @(negedge clock);
        chk("wd_sticky", timeout_err, 1);

        // Reset in the middle of WAIT, then simultaneous starts
        clear_counts();
        stub_lat = 30; stub_res = 32'h55; stub_exc = 0;
        issue(1, 0, 32'd21, 32'd22, 5'd6);
        repeat (5) @(posedge clock);
        #1 reset_n = 0;
        @(negedge clock);
        chk("midrst_stall", stall, 0);
        chk("midrst_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
        chk("midrst_opA", md_operandA, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        @(posedge clock); #1 reset_n = 1;
        repeat (35) @(posedge clock);
        chk("midrst_no_wb", wb_cnt, 0);
        clear_counts();
        stub_lat = 3; stub_res = 32'd77; stub_exc = 0;
        issue(1, 1, 32'd8, 32'd0, 5'd13);
        wait_wb(100, "both_wb_missing");
        chk("both_mult_pulses", mpulse, 1);
        chk("both_div_pulses", dpulse, 0);
        chk("both_wb_rd", last_wbr, 13);
        chk("both_wb_data", last_wbd, 77);

        // Random traffic against the model
        rand_mode = 1;
        repeat (3000) begin
            @(posedge clock); #1;
            start_mult = ($urandom_range(0, 5) == 0);
            start_div  = ($urandom_range(0, 5) == 0);
            opA  = $urandom;
            opB  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rd   = 5'($urandom);
            kill = ($urandom_range(0, 39) == 0);
            reset_n = ($urandom_range(0, 599) != 0);
        end
        @(posedge clock); #1;
        start_mult = 0; start_div = 0; kill = 0; reset_n = 1; rand_mode = 0;
        repeat (5) @(posedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
